// File: rtl/rgb_fade_ctrl_pkg.sv
// Shared definitions for the RGB fade sequencer: channel indices, frame length,
// per-channel state encoding and the saturating step function.
package rgb_fade_ctrl_pkg;

    localparam logic [1:0] CH_R   = 2'd0;
    localparam logic [1:0] CH_G   = 2'd1;
    localparam logic [1:0] CH_B   = 2'd2;
    localparam logic [1:0] CH_ALL = 2'd3;

    localparam logic [7:0] FRAME_LAST = 8'd255;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RAMP = 1'b1
    } chan_state_e;

    // Moves level toward target by at most step; lands exactly on target, never wraps.
    function automatic logic [7:0] step_toward(input logic [7:0] level,
                                               input logic [7:0] target,
                                               input logic [7:0] step);
        logic [7:0] diff;
        diff = 8'd0;
        if (target > level) begin
            diff = target - level;
            return (diff > step) ? level + step : target;
        end else if (level > target) begin
            diff = level - target;
            return (diff > step) ? level - step : target;
        end
        return level;
    endfunction

endpackage

// File: rtl/rgb_fade_ctrl_fade_chan.sv
// One fade channel: holds target/rate/divider/level and ramps the level toward
// the target on frame boundaries only.
module fade_chan
    import rgb_fade_ctrl_pkg::*;
#(
    parameter int unsigned STEP   = 1,
    parameter int unsigned RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              frame_sync,
    input  logic              load,
    input  logic [7:0]        cmd_level,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [7:0]        level,
    output logic              ramping,
    output logic              done
);

    localparam logic [7:0] STEP_L = 8'(STEP);

    chan_state_e       state;
    logic [7:0]        target;
    logic [RATE_W-1:0] rate;
    logic [RATE_W-1:0] div;
    logic [7:0]        next_level;

    assign next_level = step_toward(level, target, STEP_L);
    assign ramping    = (state == ST_RAMP);

    // NOTE: every register here is state, so non-blocking (<=) only; blocking
    // assignments in a clocked block create order-dependent simulation races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            level  <= 8'd0;
            target <= 8'd0;
            rate   <= '0;
            div    <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            // A command always wins over a coincident frame step; the level is untouched.
            if (load) begin
                target <= cmd_level;
                rate   <= cmd_rate;
                div    <= '0;
                if (cmd_level != level) begin
                    state <= ST_RAMP;
                end else begin
                    state <= ST_IDLE;
                    done  <= 1'b1;
                end
            end else if (state == ST_RAMP && frame_sync) begin
                if (div == rate) begin
                    div   <= '0;
                    level <= next_level;
                    if (next_level == target) begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end else begin
                    div <= div + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rgb_fade_ctrl.sv
// RGB fade sequencer top: frame counter aligned with the pwm instances,
// command handshake and decode, and three fade channels.
module rgb_fade_ctrl
    import rgb_fade_ctrl_pkg::*;
#(
    parameter int unsigned STEP   = 1,
    parameter int unsigned RATE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_chan,
    input  logic [7:0]        cmd_level,
    input  logic [RATE_W-1:0] cmd_rate,
    output logic [7:0]        level_r,
    output logic [7:0]        level_g,
    output logic [7:0]        level_b,
    output logic              frame_sync,
    output logic              busy,
    output logic [2:0]        done
);

    logic [7:0] frame_cnt;
    logic [2:0] load;
    logic [2:0] ramping;
    logic [7:0] level [3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt <= 8'd0;
            cmd_ready <= 1'b0;
        end else begin
            frame_cnt <= frame_cnt + 8'd1;
            cmd_ready <= 1'b1;
        end
    end

    assign frame_sync = (frame_cnt == FRAME_LAST);

    // NOTE: default every combinational output first so no path leaves it unassigned
    // (an unassigned path infers a latch).
    always_comb begin
        load = 3'b000;
        if (cmd_valid && cmd_ready) begin
            if (cmd_chan == CH_ALL) load = 3'b111;
            else                    load[cmd_chan] = 1'b1;
        end
    end

    for (genvar c = 0; c < 3; c++) begin : g_chan
        fade_chan #(
            .STEP   (STEP),
            .RATE_W (RATE_W)
        ) u_chan (
            .clk        (clk),
            .reset_n    (reset_n),
            .frame_sync (frame_sync),
            .load       (load[c]),
            .cmd_level  (cmd_level),
            .cmd_rate   (cmd_rate),
            .level      (level[c]),
            .ramping    (ramping[c]),
            .done       (done[c])
        );
    end

    assign level_r = level[CH_R];
    assign level_g = level[CH_G];
    assign level_b = level[CH_B];
    assign busy    = |ramping;

endmodule
